// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: shares one Wishbone target among N_INIT initiators.
// Round-robin grant held for a whole cyc tenure, with a watchdog that aborts
// any beat the target never terminates so a hung target cannot wedge the bus.
module wb_rr_arbiter #(
  parameter int unsigned N_INIT  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_INIT-1:0]              i_cyc,
  input  logic [N_INIT-1:0]              i_stb,
  input  logic [N_INIT-1:0]              i_we,
  input  logic [N_INIT*ADDR_W-1:0]       i_adr,
  input  logic [N_INIT*DATA_W-1:0]       i_dat_w,
  input  logic [N_INIT*(DATA_W/8)-1:0]   i_sel,
  output logic [DATA_W-1:0]              i_dat_r,
  output logic [N_INIT-1:0]              i_ack,
  output logic [N_INIT-1:0]              i_err,
  output logic                           t_cyc,
  output logic                           t_stb,
  output logic                           t_we,
  output logic [ADDR_W-1:0]              t_adr,
  output logic [DATA_W-1:0]              t_dat_w,
  output logic [DATA_W/8-1:0]            t_sel,
  input  logic [DATA_W-1:0]              t_dat_r,
  input  logic                           t_ack,
  input  logic                           t_err,
  output logic [N_INIT-1:0]              gnt
);

  localparam int unsigned IDX_W = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_INIT-1:0]  gnt_q,   gnt_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [WD_W-1:0]    wdog_q,  wdog_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  logic               cur_cyc;
  logic               cur_stb;
  logic               cur_we;
  logic [ADDR_W-1:0]  cur_adr;
  logic [DATA_W-1:0]  cur_dat_w;
  logic [SEL_W-1:0]   cur_sel;

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_INIT; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_INIT);
      if (!pick_vld && i_cyc[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Select the current owner's signals; last_q always names the owner.
  always_comb begin
    cur_cyc   = 1'b0;
    cur_stb   = 1'b0;
    cur_we    = 1'b0;
    cur_adr   = '0;
    cur_dat_w = '0;
    cur_sel   = '0;
    for (int unsigned k = 0; k < N_INIT; k++) begin
      if (last_q == IDX_W'(k)) begin
        cur_cyc   = i_cyc[k];
        cur_stb   = i_stb[k];
        cur_we    = i_we[k];
        cur_adr   = i_adr[k*ADDR_W +: ADDR_W];
        cur_dat_w = i_dat_w[k*DATA_W +: DATA_W];
        cur_sel   = i_sel[k*SEL_W +: SEL_W];
      end
    end
  end

  // Bus-facing outputs: pass-through in BUS, forced quiet in reset and elsewhere.
  always_comb begin
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    i_ack   = '0;
    i_err   = '0;
    if (!reset) begin
      case (state_q)
        ST_BUS: begin
          t_cyc = cur_cyc;
          t_stb = cur_stb;
          i_ack = gnt_q & {N_INIT{t_ack & cur_stb}};
          i_err = gnt_q & {N_INIT{t_err & cur_stb}};
        end
        ST_ABORT: begin
          i_err = gnt_q;
        end
        default: begin
        end
      endcase
    end
    t_we    = cur_we;
    t_adr   = cur_adr;
    t_dat_w = cur_dat_w;
    t_sel   = cur_sel;
    i_dat_r = t_dat_r;
    gnt     = gnt_q;
  end

  // Next-state: arbitration, tenure tracking and watchdog.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUS;
          gnt_d   = N_INIT'(1) << pick_idx;
          last_d  = pick_idx;
        end
      end
      ST_BUS: begin
        if (!cur_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (cur_stb && !t_ack && !t_err) begin
          // A terminating ack/err on the terminal cycle takes this branch's
          // else path, so it always beats the abort.
          if (wdog_q >= WD_W'(TIMEOUT - 1)) begin
            state_d = ST_ABORT;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!cur_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; initiator 0 wins first after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(N_INIT - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations, then
// random initiators/target checked every cycle against a behavioural model.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      i_cyc = '0;
  logic [N-1:0]      i_stb = '0;
  logic [N-1:0]      i_we  = '0;
  logic [N*AW-1:0]   i_adr = '0;
  logic [N*DW-1:0]   i_dat_w = '0;
  logic [N*SW-1:0]   i_sel = '0;
  logic [DW-1:0]     i_dat_r;
  logic [N-1:0]      i_ack;
  logic [N-1:0]      i_err;
  logic              t_cyc, t_stb, t_we;
  logic [AW-1:0]     t_adr;
  logic [DW-1:0]     t_dat_w;
  logic [SW-1:0]     t_sel;
  logic [DW-1:0]     t_dat_r = '0;
  logic              t_ack = 1'b0;
  logic              t_err = 1'b0;
  logic [N-1:0]      gnt;

  wb_rr_arbiter #(.N_INIT(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr),
    .i_dat_w(i_dat_w), .i_sel(i_sel), .i_dat_r(i_dat_r),
    .i_ack(i_ack), .i_err(i_err),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_adr(t_adr),
    .t_dat_w(t_dat_w), .t_sel(t_sel), .t_dat_r(t_dat_r),
    .t_ack(t_ack), .t_err(t_err), .gnt(gnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int k);
    logic [N-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  // Behavioural model: who owns the bus, whether the owner's beat was
  // aborted (and we are waiting for it to let go), and how long it has stalled.
  bit  m_known = 0;
  int  m_owner = -1;
  int  m_ptr   = N - 1;
  int  m_wait  = 0;
  bit  m_abort = 0;
  bit  m_dead  = 0;
  int  m_cand;

  logic [N-1:0] e_ack, e_err;
  logic         e_cyc, e_stb;
  logic [N-1:0] obs_ack = '0, obs_err = '0;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clock) begin
    e_cyc = 1'b0; e_stb = 1'b0; e_ack = '0; e_err = '0;
    if (!reset && m_owner >= 0) begin
      if (m_abort) begin
        e_err = N'(1) << m_owner;
      end else if (!m_dead) begin
        e_cyc = bit_of(i_cyc, m_owner);
        e_stb = bit_of(i_stb, m_owner);
        if (t_ack && e_stb) e_ack = N'(1) << m_owner;
        if (t_err && e_stb) e_err = N'(1) << m_owner;
      end
    end
    chk("t_cyc", 64'(t_cyc), 64'(e_cyc));
    chk("t_stb", 64'(t_stb), 64'(e_stb));
    chk("i_ack", 64'(i_ack), 64'(e_ack));
    chk("i_err", 64'(i_err), 64'(e_err));
    chk("i_dat_r", 64'(i_dat_r), 64'(t_dat_r));
    if (m_known && !reset)
      chk("gnt", 64'(gnt), (m_owner >= 0) ? 64'(N'(1) << m_owner) : 64'(0));
    if (e_cyc) begin
      chk("t_adr",   64'(t_adr),   64'(AW'(i_adr   >> (m_owner * AW))));
      chk("t_dat_w", 64'(t_dat_w), 64'(DW'(i_dat_w >> (m_owner * DW))));
      chk("t_sel",   64'(t_sel),   64'(SW'(i_sel   >> (m_owner * SW))));
      chk("t_we",    64'(t_we),    64'(bit_of(i_we, m_owner)));
    end
    obs_ack = i_ack;
    obs_err = i_err;

    if (reset) begin
      m_known = 1; m_owner = -1; m_ptr = N - 1; m_wait = 0; m_abort = 0; m_dead = 0;
    end else if (m_owner < 0) begin
      for (int j = 1; j <= N; j++) begin
        m_cand = (m_ptr + j) % N;
        if (m_owner < 0 && bit_of(i_cyc, m_cand)) m_owner = m_cand;
      end
      if (m_owner >= 0) m_ptr = m_owner;
      m_wait = 0;
    end else if (m_abort) begin
      m_abort = 0; m_dead = 1;
    end else if (m_dead) begin
      if (!bit_of(i_cyc, m_owner)) begin m_dead = 0; m_owner = -1; end
    end else begin
      if (!bit_of(i_cyc, m_owner)) begin
        m_owner = -1; m_wait = 0;
      end else if (bit_of(i_stb, m_owner) && !t_ack && !t_err) begin
        m_wait++;
        if (m_wait == TO) begin m_abort = 1; m_wait = 0; end
      end else begin
        m_wait = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_init(input int k, input logic cyc, input logic stb, input logic we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel);
    i_cyc[k] = cyc;
    i_stb[k] = stb;
    i_we[k]  = we;
    i_adr[k*AW +: AW]   = adr;
    i_dat_w[k*DW +: DW] = dat;
    i_sel[k*SW +: SW]   = sel;
  endtask

  int beats [N];
  int hang = 0;
  int r;

  initial begin
    // Single write from init0, acked on its first grant cycle.
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_tcyc", 64'(t_cyc), 64'(0));
    set_init(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    tick();
    chk("d1_gnt", 64'(gnt), 64'(3'b001));
    chk("d1_tcyc", 64'(t_cyc), 64'(1));
    chk("d1_adr", 64'(t_adr), 64'(32'h100));
    chk("d1_dat", 64'(t_dat_w), 64'(32'hDEADBEEF));
    t_ack = 1'b1; #1;
    chk("d1_ack", 64'(i_ack), 64'(3'b001));
    tick();
    set_init(0, 0, 0, 0, 0, 0, 0); t_ack = 1'b0; #1;
    chk("d1_ack_once", 64'(i_ack), 64'(0));
    tick();
    chk("d1_release", 64'(gnt), 64'(0));

    // Simultaneous requests after reset: init0 first, idle gap, then init1.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    set_init(0, 1, 1, 0, 32'h200, 0, 4'hF);
    set_init(1, 1, 1, 0, 32'h300, 0, 4'h3);
    tick();
    chk("d2_gnt0", 64'(gnt), 64'(3'b001));
    t_ack = 1'b1; #1;
    chk("d2_ack0", 64'(i_ack), 64'(3'b001));
    tick();
    set_init(0, 0, 0, 0, 0, 0, 0); t_ack = 1'b0;
    tick();
    chk("d2_gap_gnt", 64'(gnt), 64'(0));
    chk("d2_gap_cyc", 64'(t_cyc), 64'(0));
    tick();
    chk("d2_gnt1", 64'(gnt), 64'(3'b010));
    chk("d2_adr1", 64'(t_adr), 64'(32'h300));
    t_ack = 1'b1; #1;
    chk("d2_ack1", 64'(i_ack), 64'(3'b010));
    tick();
    set_init(1, 0, 0, 0, 0, 0, 0); t_ack = 1'b0;
    tick(); tick();

    // Hung target: err exactly 16 cycles after stb, then drain.
    set_init(0, 1, 1, 0, 32'h10, 0, 4'hF);
    tick();
    chk("d5_gnt", 64'(gnt), 64'(3'b001));
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("d5_no_early_err", 64'(i_err), 64'(0));
    end
    tick();
    chk("d5_abort_err", 64'(i_err), 64'(3'b001));
    chk("d5_abort_cyc", 64'(t_cyc), 64'(0));
    tick();
    chk("d5_err_once", 64'(i_err), 64'(0));
    chk("d5_drain_cyc", 64'(t_cyc), 64'(0));
    set_init(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Ack on the terminal watchdog cycle wins over the abort.
    set_init(0, 1, 1, 0, 32'h14, 0, 4'hF);
    tick();
    for (int i = 1; i < TO; i++) tick();
    t_ack = 1'b1; #1;
    chk("d7_late_ack", 64'(i_ack), 64'(3'b001));
    tick();
    chk("d7_no_abort", 64'(i_err), 64'(0));
    chk("d7_still_cyc", 64'(t_cyc), 64'(1));
    set_init(0, 0, 0, 0, 0, 0, 0); t_ack = 1'b0;
    tick(); tick();

    // Reset in the middle of a beat.
    set_init(1, 1, 1, 1, 32'h40, 32'h1234, 4'h1);
    tick();
    chk("d6_tcyc", 64'(t_cyc), 64'(1));
    reset = 1'b1; t_ack = 1'b1; #1;
    chk("d6_rst_cyc", 64'(t_cyc), 64'(0));
    chk("d6_rst_ack", 64'(i_ack), 64'(0));
    tick();
    chk("d6_rst_gnt", 64'(gnt), 64'(0));
    reset = 1'b0; t_ack = 1'b0;
    set_init(0, 1, 1, 0, 32'h50, 0, 4'hF);
    tick();
    chk("d6_first_gnt", 64'(gnt), 64'(3'b001));
    i_cyc = '0; i_stb = '0;
    tick(); tick(); tick();

    // Random initiators and target.
    for (int k = 0; k < N; k++) beats[k] = 0;
    for (int cyc_n = 0; cyc_n < 4000; cyc_n++) begin
      reset = ($urandom_range(0, 399) == 0);
      t_dat_r = DW'($urandom);
      if (hang > 0) begin
        hang--; t_ack = 1'b0; t_err = 1'b0;
      end else begin
        r = int'($urandom_range(0, 9));
        t_ack = (r < 4);
        t_err = (r == 4);
        if ($urandom_range(0, 59) == 0) hang = int'($urandom_range(20, 40));
      end
      for (int k = 0; k < N; k++) begin
        if (!i_cyc[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            beats[k] = int'($urandom_range(1, 3));
            set_init(k, 1, 1, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
          end
        end else if (i_stb[k] && obs_err[k]) begin
          set_init(k, 0, 0, 0, 0, 0, 0);
        end else if (i_stb[k] && obs_ack[k]) begin
          beats[k]--;
          if (beats[k] <= 0) set_init(k, 0, 0, 0, 0, 0, 0);
          else if ($urandom_range(0, 2) == 0) i_stb[k] = 1'b0;
          else set_init(k, 1, 1, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
        end else if (!i_stb[k]) begin
          set_init(k, 1, 1, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
        end
      end
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
